// File: rtl/fixed_length_field_decoder.sv
// Sequential u(n)/i(n) slice-header field extractor that pulls bits from a bitstream window.
// Optional macro FLD_SIGNED_EN turns req_sel=3 into an i(req_len) signed decode instead of u(1).
module fixed_length_field_decoder #(
  parameter int WIN_W   = 16,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         cfg_log2_max_frame_num_minus4,
  input  logic [3:0]         cfg_log2_max_poc_lsb_minus4,
  input  logic               req,
  input  logic [1:0]         req_sel,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [WIN_W-1:0]   bs_window,
  input  logic               bs_valid,
  output logic               consume_valid,
  output logic [LEN_W-1:0]   consume_len,
  output logic [MAX_LEN-1:0] out_value,
  output logic               out_valid,
  output logic               out_err,
  output logic               busy
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

  localparam logic [LEN_W-1:0] WIN_LEN   = LEN_W'(WIN_W);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [MAX_LEN-1:0] acc_q, acc_d;
  logic               err_q, err_d;
  logic               consume_valid_q, consume_valid_d;
  logic [LEN_W-1:0]   consume_len_q, consume_len_d;
  logic [MAX_LEN-1:0] out_value_q, out_value_d;
  logic               out_valid_q, out_valid_d;
  logic               out_err_q, out_err_d;
  logic               busy_q, busy_d;
  logic [LEN_W-1:0]   req_len_sel;
  logic               sps_bad;
  logic               req_illegal;
  logic [LEN_W-1:0]   n;
`ifdef FLD_SIGNED_EN
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sgn_q, sgn_d;
  logic               sign_bit;
`endif

  // Field length and legality of whatever is on the request inputs; only used at acceptance.
  always_comb begin
    req_len_sel = '0;
    sps_bad     = 1'b0;
    case (req_sel)
      2'd0: begin
        req_len_sel = LEN_W'(cfg_log2_max_frame_num_minus4) + LEN_W'(4);
        sps_bad     = cfg_log2_max_frame_num_minus4 > 4'd12;
      end
      2'd1: begin
        req_len_sel = LEN_W'(cfg_log2_max_poc_lsb_minus4) + LEN_W'(4);
        sps_bad     = cfg_log2_max_poc_lsb_minus4 > 4'd12;
      end
      2'd2: req_len_sel = req_len;
      default: begin
`ifdef FLD_SIGNED_EN
        req_len_sel = req_len;
`else
        req_len_sel = LEN_W'(1);
`endif
      end
    endcase
    req_illegal = sps_bad || (req_len_sel > MAX_LEN_L);
  end

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    acc_d           = acc_q;
    err_d           = err_q;
    consume_valid_d = 1'b0;
    consume_len_d   = '0;
    out_value_d     = out_value_q;
    out_valid_d     = 1'b0;
    out_err_d       = 1'b0;
    n               = (rem_q < WIN_LEN) ? rem_q : WIN_LEN;
`ifdef FLD_SIGNED_EN
    len_d    = len_q;
    sgn_d    = sgn_q;
    sign_bit = |(acc_q & (MAX_LEN'(1) << (len_q - LEN_W'(1))));
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          acc_d   = '0;
          err_d   = req_illegal;
          rem_d   = req_illegal ? '0 : req_len_sel;
          state_d = (req_illegal || req_len_sel == '0) ? S_DONE : S_FETCH;
`ifdef FLD_SIGNED_EN
          len_d = req_len_sel;
          sgn_d = (req_sel == 2'd3);
`endif
        end
      end
      S_FETCH: begin
        if (bs_valid) begin
          // Take the top n window bits and append them below what was already gathered.
          acc_d           = (acc_q << n) | MAX_LEN'(bs_window >> (WIN_LEN - n));
          consume_valid_d = 1'b1;
          consume_len_d   = n;
          rem_d           = rem_q - n;
          state_d         = (rem_q == n) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: state_d = S_FETCH;
      S_DONE: begin
        out_valid_d = 1'b1;
        out_err_d   = err_q;
        out_value_d = err_q ? '0 : acc_q;
`ifdef FLD_SIGNED_EN
        if (!err_q && sgn_q && len_q != '0 && sign_bit)
          out_value_d = acc_q | ({MAX_LEN{1'b1}} << len_q);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rem_q           <= '0;
      acc_q           <= '0;
      err_q           <= 1'b0;
      consume_valid_q <= 1'b0;
      consume_len_q   <= '0;
      out_value_q     <= '0;
      out_valid_q     <= 1'b0;
      out_err_q       <= 1'b0;
      busy_q          <= 1'b0;
`ifdef FLD_SIGNED_EN
      len_q <= '0;
      sgn_q <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      acc_q           <= acc_d;
      err_q           <= err_d;
      consume_valid_q <= consume_valid_d;
      consume_len_q   <= consume_len_d;
      out_value_q     <= out_value_d;
      out_valid_q     <= out_valid_d;
      out_err_q       <= out_err_d;
      busy_q          <= busy_d;
`ifdef FLD_SIGNED_EN
      len_q <= len_d;
      sgn_q <= sgn_d;
`endif
    end
  end

  assign consume_valid = consume_valid_q;
  assign consume_len   = consume_len_q;
  assign out_value     = out_value_q;
  assign out_valid     = out_valid_q;
  assign out_err       = out_err_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_fixed_length_field_decoder.sv
// Bench for fixed_length_field_decoder: a bit-pointer buffer model feeds the window,
// expected field results go through a scoreboard queue.
module tb_fixed_length_field_decoder;
  localparam int WIN_W = 16, MAX_LEN = 32, LEN_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] cfg_f = 4'd0, cfg_p = 4'd0;
  logic req = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic [LEN_W-1:0] req_len = '0;
  logic [WIN_W-1:0] bs_window;
  logic bs_valid = 1'b1;
  logic consume_valid, out_valid, out_err, busy;
  logic [LEN_W-1:0] consume_len;
  logic [MAX_LEN-1:0] out_value;

  fixed_length_field_decoder #(.WIN_W(WIN_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(rst),
    .cfg_log2_max_frame_num_minus4(cfg_f), .cfg_log2_max_poc_lsb_minus4(cfg_p),
    .req(req), .req_sel(req_sel), .req_len(req_len),
    .bs_window(bs_window), .bs_valid(bs_valid),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .out_value(out_value), .out_valid(out_valid), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bitstream buffer model: window shows the bits at ptr, advanced by each consume pulse.
  logic [255:0] stream = '0;
  logic ptr_clr = 1'b1;
  int ptr = 0;
  always @(posedge clk) begin
    if (ptr_clr) ptr <= 0;
    else if (consume_valid) ptr <= ptr + int'(consume_len);
  end
  assign bs_window = WIN_W'(stream >> (240 - ptr));

  int cons_log[$];
  logic prev_cv = 1'b0;
  int adj_err = 0, len_viol = 0;
  always @(negedge clk) begin
    if (consume_valid) cons_log.push_back(int'(consume_len));
    if (consume_valid && prev_cv) adj_err <= adj_err + 1;
    if (!consume_valid && consume_len != '0) len_viol <= len_viol + 1;
    prev_cv <= consume_valid;
  end

  typedef struct { logic [MAX_LEN-1:0] val; logic err; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;

  task automatic load(input logic [255:0] s);
    stream  = s;
    ptr_clr = 1'b1;
    @(negedge clk);
    ptr_clr = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] sel, input logic [LEN_W-1:0] len);
    req = 1'b1; req_sel = sel; req_len = len;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit tmo);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    tmo = (out_valid !== 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({consume_valid, consume_len, out_value, out_valid, out_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cv=%b cl=%0d val=%h ov=%b oe=%b busy=%b, expected all 0",
               consume_valid, consume_len, out_value, out_valid, out_err, busy);
    end
    rst = 1'b0; ptr_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_num();
    int lat, idx; bit tmo; exp_t e;
    cfg_f = 4'd0;
    load({16'hA5C3, 240'h0});
    idx = cons_log.size();
    exp_q.push_back('{32'hA, 1'b0});
    send_req(2'd0, '0);
    cfg_f = 4'd9;
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || lat != 3) begin n_fail++; $display("FAIL t1_latency: got %0d (timeout %0b), expected 3", lat, tmo); end
    n_checks++;
    if (out_value !== e.val || out_err !== e.err) begin
      n_fail++; $display("FAIL t1_value: got %h err %b, expected %h err %b", out_value, out_err, e.val, e.err);
    end
    n_checks++;
    if (cons_log.size() - idx != 1 || cons_log[idx] != 4) begin
      n_fail++; $display("FAIL t1_consume: got %0d pulses, expected one of 4", cons_log.size() - idx);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_width: out_valid got %b, expected 0", out_valid); end
    cfg_f = 4'd0;
  endtask

  task automatic test_poc_lsb();
    int lat, idx; bit tmo; exp_t e;
    cfg_p = 4'd12;
    load({16'h8001, 240'h0});
    idx = cons_log.size();
    exp_q.push_back('{32'h8001, 1'b0});
    send_req(2'd1, '0);
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || lat != 3) begin n_fail++; $display("FAIL t2_latency: got %0d (timeout %0b), expected 3", lat, tmo); end
    n_checks++;
    if (out_value !== e.val || out_err !== e.err) begin
      n_fail++; $display("FAIL t2_value: got %h err %b, expected %h err %b", out_value, out_err, e.val, e.err);
    end
    n_checks++;
    if (cons_log.size() - idx != 1 || cons_log[idx] != 16) begin
      n_fail++; $display("FAIL t2_consume: got %0d pulses, expected one of 16", cons_log.size() - idx);
    end
  endtask

  task automatic test_multi_window();
    int lat, idx; bit tmo; exp_t e;
    load({32'h1234_5678, 224'h0});
    idx = cons_log.size();
    exp_q.push_back('{32'h1234_5678, 1'b0});
    send_req(2'd2, 6'd32);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t3_busy: got %b, expected 1", busy); end
    @(negedge clk);
    bs_valid = 1'b0;
    repeat (3) @(negedge clk);
    bs_valid = 1'b1;
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || out_value !== e.val || out_err !== e.err) begin
      n_fail++; $display("FAIL t3_value: got %h err %b (timeout %0b), expected %h", out_value, out_err, tmo, e.val);
    end
    n_checks++;
    if (cons_log.size() - idx != 2 || cons_log[idx] != 16 || cons_log[idx+1] != 16 || ptr != 32) begin
      n_fail++; $display("FAIL t3_consume: got %0d pulses, ptr %0d, expected 16,16 ptr 32", cons_log.size() - idx, ptr);
    end
  endtask

  task automatic test_illegal();
    int lat, idx; bit tmo; exp_t e;
    logic [1:0] sels [3] = '{2'd2, 2'd0, 2'd2};
    logic [LEN_W-1:0] lens [3] = '{6'd33, 6'd0, 6'd0};
    logic errs [3] = '{1'b1, 1'b1, 1'b0};
    load({16'hFFFF, 240'h0});
    for (int i = 0; i < 3; i++) begin
      cfg_f = (i == 1) ? 4'd13 : 4'd0;
      idx = cons_log.size();
      exp_q.push_back('{32'h0, errs[i]});
      send_req(sels[i], lens[i]);
      wait_out(lat, tmo);
      e = exp_q.pop_front();
      n_checks++;
      if (tmo || out_value !== e.val || out_err !== e.err) begin
        n_fail++; $display("FAIL t4_case%0d: got %h err %b (timeout %0b), expected %h err %b",
                           i, out_value, out_err, tmo, e.val, e.err);
      end
      n_checks++;
      if (cons_log.size() != idx) begin
        n_fail++; $display("FAIL t4_noconsume%0d: got %0d pulses, expected 0", i, cons_log.size() - idx);
      end
    end
    cfg_f = 4'd0;
  endtask

  task automatic test_reset_mid_field();
    int lat, idx; bit tmo; exp_t e;
    load({32'h1234_5678, 224'h0});
    send_req(2'd2, 6'd32);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({consume_valid, consume_len, out_value, out_valid, out_err, busy} !== '0) begin
      n_fail++; $display("FAIL t5_reset_outputs: got cv=%b cl=%0d val=%h busy=%b, expected all 0",
                         consume_valid, consume_len, out_value, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    idx = cons_log.size();
    repeat (4) @(negedge clk);
    n_checks++;
    if (cons_log.size() != idx || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_idle_after_reset: got %0d pulses busy %b, expected 0 and 0", cons_log.size() - idx, busy);
    end
    cfg_f = 4'd4;
    load({16'hC3FF, 240'h0});
    idx = cons_log.size();
    exp_q.push_back('{32'hC3, 1'b0});
    send_req(2'd0, '0);
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || out_value !== e.val || out_err !== e.err || cons_log.size() - idx != 1 || cons_log[idx] != 8) begin
      n_fail++; $display("FAIL t5_after_reset: got %h err %b pulses %0d, expected %h with one consume of 8",
                         out_value, out_err, cons_log.size() - idx, e.val);
    end
    cfg_f = 4'd0;
  endtask

  task automatic test_back_to_back();
    int lat, idx; bit tmo; exp_t e;
    load({16'hF0A5, 240'h0});
    idx = cons_log.size();
    exp_q.push_back('{32'hF0, 1'b0});
    send_req(2'd2, 6'd8);
    send_req(2'd2, 6'd4);
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || out_value !== e.val || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got %h busy %b (timeout %0b), expected %h busy 0", out_value, busy, tmo, e.val);
    end
    exp_q.push_back('{32'hA, 1'b0});
    send_req(2'd2, 6'd4);
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || out_value !== e.val) begin
      n_fail++; $display("FAIL b2b_second: got %h (timeout %0b), expected %h", out_value, tmo, e.val);
    end
    n_checks++;
    if (cons_log.size() - idx != 2 || cons_log[idx] != 8 || cons_log[idx+1] != 4) begin
      n_fail++; $display("FAIL b2b_consume: got %0d pulses, expected 8 then 4", cons_log.size() - idx);
    end
  endtask

  task automatic test_sel3();
    int lat, idx, ncons; bit tmo; exp_t e;
    load({16'hD800, 240'h0});
    idx = cons_log.size();
`ifdef FLD_SIGNED_EN
    exp_q.push_back('{32'hFFFF_FFFB, 1'b0});
    ncons = 5;
`else
    exp_q.push_back('{32'h1, 1'b0});
    ncons = 1;
`endif
    send_req(2'd3, 6'd5);
    wait_out(lat, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || out_value !== e.val || out_err !== e.err) begin
      n_fail++; $display("FAIL t6_value: got %h err %b (timeout %0b), expected %h", out_value, out_err, tmo, e.val);
    end
    n_checks++;
    if (cons_log.size() - idx != 1 || cons_log[idx] != ncons) begin
      n_fail++; $display("FAIL t6_consume: got %0d pulses, expected one of %0d", cons_log.size() - idx, ncons);
    end
  endtask

  task automatic test_protocol();
    @(negedge clk);
    n_checks++;
    if (adj_err != 0 || len_viol != 0) begin
      n_fail++; $display("FAIL protocol: got %0d adjacent pulses, %0d idle nonzero lengths, expected 0 and 0", adj_err, len_viol);
    end
  endtask

  initial begin
    test_reset();
    test_frame_num();
    test_poc_lsb();
    test_multi_window();
    test_illegal();
    test_reset_mid_field();
    test_back_to_back();
    test_sel3();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
